// File: rtl/disp_median3x3.sv
// 3x3 median filter over vertically aligned disparity taps, raster order, with end-of-frame flush.
// Optional MEDIAN_BORDER_ZERO_EN: border pixels emit 0 instead of the centre value.
module disp_median3x3 #(
   parameter int unsigned DWIDTH = 18,
   parameter int unsigned AWIDTH = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clken_i,
   input  logic [AWIDTH-1:0] width_i,
   input  logic [AWIDTH-1:0] height_i,
   input  logic              in_valid_i,
   input  logic [DWIDTH-1:0] top_i,
   input  logic [DWIDTH-1:0] mid_i,
   input  logic [DWIDTH-1:0] bot_i,
   output logic [DWIDTH-1:0] dout_o,
   output logic              out_valid_o,
   output logic              frame_done_o
);

   typedef logic [DWIDTH-1:0] pix_t;
   typedef logic [2:0][DWIDTH-1:0] col_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush
   } state_e;

   function automatic pix_t min2(input pix_t a, input pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t max2(input pix_t a, input pix_t b);
      return (a < b) ? b : a;
   endfunction

   function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
      return min2(min2(a, b), c);
   endfunction

   function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
      return max2(max2(a, b), c);
   endfunction

   function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   state_e state_q, state_d;

   logic [AWIDTH-1:0] wid_q, wid_d, hgt_q, hgt_d;
   logic [AWIDTH-1:0] ic_q, ic_d, ir_q, ir_d;
   logic [AWIDTH-1:0] cc_q, cc_d, cr_q, cr_d;
   logic [AWIDTH-1:0] w_m1, wid_m1, hgt_m1;

   logic accept, flush_beat, shift, last_beat;

   // Window: col_q[0] newest column, col_q[1] centre column; each column is {bot, mid, top}.
   col_t col_q [3];
   logic win_vld_q, win_vld_d;
   logic win_brd_q, win_brd_d;
   logic win_last_q, win_last_d;

   col_t s1_min_q, s1_med_q, s1_max_q;
   col_t s1_min_d, s1_med_d, s1_max_d;
   pix_t s1_ctr_q;
   logic s1_vld_q, s1_brd_q, s1_last_q;

   pix_t s2_lo_q, s2_md_q, s2_hi_q, s2_ctr_q;
   logic s2_vld_q, s2_brd_q, s2_last_q;

   pix_t dout_q;
   logic out_valid_q, frame_done_q;
   pix_t border_val;

   assign accept     = clken_i & in_valid_i & (state_q != StFlush);
   assign flush_beat = clken_i & (state_q == StFlush);
   assign shift      = accept | flush_beat;

   assign wid_m1 = wid_q - AWIDTH'(1);
   assign hgt_m1 = hgt_q - AWIDTH'(1);
   assign w_m1   = (state_q == StIdle) ? (width_i - AWIDTH'(1)) : wid_m1;

   assign last_beat = accept & (state_q == StRun) & (ic_q == wid_m1) & (ir_q == hgt_m1);

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (last_beat) state_d = StFlush;
         StFlush: if (clken_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Frame geometry latch and input counters
   always_comb begin
      wid_d = wid_q;
      hgt_d = hgt_q;
      ic_d  = ic_q;
      ir_d  = ir_q;
      if (accept && state_q == StIdle) begin
         wid_d = width_i;
         hgt_d = height_i;
      end
      if (accept) begin
         if (last_beat) begin
            ic_d = '0;
            ir_d = '0;
         end else if (ic_q == w_m1) begin
            ic_d = '0;
            ir_d = ir_q + AWIDTH'(1);
         end else begin
            ic_d = ic_q + AWIDTH'(1);
         end
      end
   end

   // Centre counters trail the input counters; the first beat of a frame only primes the window.
   always_comb begin
      cc_d       = cc_q;
      cr_d       = cr_q;
      win_vld_d  = 1'b0;
      win_brd_d  = win_brd_q;
      win_last_d = 1'b0;
      if (shift && state_q != StIdle) begin
         win_vld_d  = 1'b1;
         win_brd_d  = (cr_q == '0) | (cr_q == hgt_m1) | (cc_q == '0) | (cc_q == wid_m1);
         win_last_d = flush_beat;
         if (flush_beat) begin
            cc_d = '0;
            cr_d = '0;
         end else if (cc_q == wid_m1) begin
            cc_d = '0;
            cr_d = cr_q + AWIDTH'(1);
         end else begin
            cc_d = cc_q + AWIDTH'(1);
         end
      end
   end

   // S1: per-column sort
   always_comb begin
      s1_min_d = '0;
      s1_med_d = '0;
      s1_max_d = '0;
      for (int k = 0; k < 3; k++) begin
         s1_min_d[k] = min3(col_q[k][0], col_q[k][1], col_q[k][2]);
         s1_med_d[k] = med3(col_q[k][0], col_q[k][1], col_q[k][2]);
         s1_max_d[k] = max3(col_q[k][0], col_q[k][1], col_q[k][2]);
      end
   end

`ifdef MEDIAN_BORDER_ZERO_EN
   assign border_val = '0;
`else
   assign border_val = s2_ctr_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         wid_q   <= '0;
         hgt_q   <= '0;
         ic_q    <= '0;
         ir_q    <= '0;
         cc_q    <= '0;
         cr_q    <= '0;
      end else if (clken_i) begin
         state_q <= state_d;
         wid_q   <= wid_d;
         hgt_q   <= hgt_d;
         ic_q    <= ic_d;
         ir_q    <= ir_d;
         cc_q    <= cc_d;
         cr_q    <= cr_d;
      end
   end

   // Window shift; flush beat shifts whatever is on the taps, which only feeds border output.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < 3; k++) col_q[k] <= '0;
         win_vld_q  <= 1'b0;
         win_brd_q  <= 1'b0;
         win_last_q <= 1'b0;
      end else if (clken_i) begin
         if (shift) begin
            col_q[2] <= col_q[1];
            col_q[1] <= col_q[0];
            col_q[0] <= {bot_i, mid_i, top_i};
         end
         win_vld_q  <= win_vld_d;
         win_brd_q  <= win_brd_d;
         win_last_q <= win_last_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_min_q  <= '0;
         s1_med_q  <= '0;
         s1_max_q  <= '0;
         s1_ctr_q  <= '0;
         s1_vld_q  <= 1'b0;
         s1_brd_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s2_lo_q   <= '0;
         s2_md_q   <= '0;
         s2_hi_q   <= '0;
         s2_ctr_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_brd_q  <= 1'b0;
         s2_last_q <= 1'b0;
      end else if (clken_i) begin
         s1_min_q  <= s1_min_d;
         s1_med_q  <= s1_med_d;
         s1_max_q  <= s1_max_d;
         s1_ctr_q  <= col_q[1][1];
         s1_vld_q  <= win_vld_q;
         s1_brd_q  <= win_brd_q;
         s1_last_q <= win_last_q;
         s2_lo_q   <= max3(s1_min_q[0], s1_min_q[1], s1_min_q[2]);
         s2_md_q   <= med3(s1_med_q[0], s1_med_q[1], s1_med_q[2]);
         s2_hi_q   <= min3(s1_max_q[0], s1_max_q[1], s1_max_q[2]);
         s2_ctr_q  <= s1_ctr_q;
         s2_vld_q  <= s1_vld_q;
         s2_brd_q  <= s1_brd_q;
         s2_last_q <= s1_last_q;
      end
   end

   // S3: final median or border value; dout holds between valid outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dout_q       <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else if (clken_i) begin
         if (s2_vld_q) begin
            dout_q <= s2_brd_q ? border_val : med3(s2_lo_q, s2_md_q, s2_hi_q);
         end
         out_valid_q  <= s2_vld_q;
         frame_done_q <= s2_vld_q & s2_last_q;
      end
   end

   assign dout_o       = dout_q;
   assign out_valid_o  = out_valid_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_disp_median3x3.sv
// Directed bench for disp_median3x3: ramps, spike removal, bubbles, clken freeze, mid-frame reset.
module tb_disp_median3x3;

   localparam int DW = 18;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clken = 1'b1;
   logic [AW-1:0] width = '0;
   logic [AW-1:0] height = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] top = '0, mid = '0, bot = '0;
   logic [DW-1:0] dout;
   logic          out_valid;
   logic          frame_done;

   disp_median3x3 #(
      .DWIDTH(DW),
      .AWIDTH(AW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clken_i     (clken),
      .width_i     (width),
      .height_i    (height),
      .in_valid_i  (in_valid),
      .top_i       (top),
      .mid_i       (mid),
      .bot_i       (bot),
      .dout_o      (dout),
      .out_valid_o (out_valid),
      .frame_done_o(frame_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output capture: a new output is one registered on a clken edge.
   logic          en_s = 1'b1;
   int            cyc = 0;
   logic [DW-1:0] oq[$];
   logic          fq[$];
   int            cq[$];

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      en_s <= clken;
   end

   always @(negedge clk) begin
      if (!rst && en_s && out_valid) begin
         oq.push_back(dout);
         fq.push_back(frame_done);
         cq.push_back(cyc);
      end
   end

`ifdef MEDIAN_BORDER_ZERO_EN
   localparam bit BrdZero = 1'b1;
   int ramp3_exp[9] = '{0, 0, 0, 0, 5, 0, 0, 0, 0};
`else
   localparam bit BrdZero = 1'b0;
   int ramp3_exp[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
`endif

   function automatic int pix(input int mode, input int r, input int c, input int w);
      if (mode == 0) return r * w + c + 1;
      return (r == 1 && c == 1) ? 200 : 10;
   endfunction

   // Linear ramp: interior median equals the centre; spike image: interior median is 10.
   function automatic int expv(input int mode, input int r, input int c, input int w, input int h);
      if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return BrdZero ? 0 : pix(mode, r, c, w);
      return (mode == 0) ? pix(mode, r, c, w) : 10;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      oq.delete();
      fq.delete();
      cq.delete();
   endtask

   task automatic send_frame(input int w, input int h, input int mode, input bit gap,
                             input int freeze_at, input int nbeats);
      logic [DW-1:0] sd;
      logic          sv;
      width  = AW'(w);
      height = AW'(h);
      for (int i = 0; i < nbeats; i++) begin
         int r = i / w;
         int c = i % w;
         top      = (r > 0) ? DW'(pix(mode, r - 1, c, w)) : '0;
         mid      = DW'(pix(mode, r, c, w));
         bot      = (r < h - 1) ? DW'(pix(mode, r + 1, c, w)) : '0;
         in_valid = 1'b1;
         if (i == freeze_at) begin
            sd    = dout;
            sv    = out_valid;
            clken = 1'b0;
            for (int k = 0; k < 5; k++) begin
               step();
               check($sformatf("freeze_valid%0d", k), 32'(out_valid), 32'(sv));
               check($sformatf("freeze_dout%0d", k), 32'(dout), 32'(sd));
            end
            clken = 1'b1;
         end
         step();
         if (gap) begin
            in_valid = 1'b0;
            step();
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input int n);
      int k = 0;
      while (oq.size() < n && k < 60) begin
         step();
         k++;
      end
      repeat (4) step();
      check({tag, "_count"}, 32'(oq.size()), 32'(n));
   endtask

   task automatic check_frame(input string tag, input int w, input int h, input int mode);
      wait_frame(tag, w * h);
      for (int i = 0; i < oq.size() && i < w * h; i++) begin
         check($sformatf("%s_px%0d", tag, i), 32'(oq[i]), 32'(expv(mode, i / w, i % w, w, h)));
         check($sformatf("%s_fd%0d", tag, i), 32'(fq[i]), 32'(i == w * h - 1));
      end
   endtask

   initial begin
      #3 rst = 1'b1;
      #1;
      check("reset_dout", 32'(dout), 0);
      check("reset_valid", 32'(out_valid), 0);
      check("reset_fd", 32'(frame_done), 0);
      step();
      step();
      rst = 1'b0;
      step();

      // 3x3 ramp, gap-free
      clear_q();
      send_frame(3, 3, 0, 1'b0, -1, 9);
      wait_frame("ramp3", 9);
      for (int i = 0; i < oq.size() && i < 9; i++) begin
         check($sformatf("ramp3_px%0d", i), 32'(oq[i]), 32'(ramp3_exp[i]));
         check($sformatf("ramp3_fd%0d", i), 32'(fq[i]), 32'(i == 8));
      end

      // 4x3 spike removal
      clear_q();
      send_frame(4, 3, 1, 1'b0, -1, 12);
      check_frame("spike", 4, 3, 1);

      // 3x3 ramp with in_valid 1,0,1,0 bubbles
      clear_q();
      send_frame(3, 3, 0, 1'b1, -1, 9);
      wait_frame("gap", 9);
      for (int i = 0; i < oq.size() && i < 9; i++) begin
         check($sformatf("gap_px%0d", i), 32'(oq[i]), 32'(ramp3_exp[i]));
         if (i > 0) check($sformatf("gap_space%0d", i), 32'(cq[i] - cq[i-1]), (i == 8) ? 1 : 2);
      end

      // 4x4 ramp with clken low for 5 cycles mid-frame
      clear_q();
      send_frame(4, 4, 0, 1'b0, 6, 16);
      check_frame("freeze", 4, 4, 0);

      // Reset during row 1, then a clean 4x4 frame
      clear_q();
      send_frame(4, 4, 0, 1'b0, -1, 5);
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 0);
      check("midrst_dout", 32'(dout), 0);
      step();
      rst = 1'b0;
      step();
      clear_q();
      send_frame(4, 4, 0, 1'b0, -1, 16);
      check_frame("after_rst", 4, 4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/disp_median3x3.md
Name: disp_median3x3

Overview:
- Downstream consumer of the post-processing line-buffer FIFO chain.
- Takes three vertically aligned disparity taps per beat (row above, current row, row below), forms a 3x3 window, and emits the median-filtered disparity for each pixel in raster order.
- Border pixels pass through unfiltered.
- A flush state drains the final pixel of each frame and pulses frame_done.

Parameters:
- DWIDTH, 18, pixel/disparity word width; compared as unsigned.
- AWIDTH, 11, width of the column/row counters and of the width/height inputs.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- clken  in  1  global clock enable; nothing advances when low.
- width  in  AWIDTH  line length in pixels; minimum 3.
- height  in  AWIDTH  frame height in lines; minimum 3.
- in_valid  in  1  taps valid this cycle.
- top  in  DWIDTH  pixel (r-1,c).
- mid  in  DWIDTH  pixel (r,c).
- bot  in  DWIDTH  pixel (r+1,c).
- dout  out  DWIDTH  filtered pixel.
- out_valid  out  1  dout valid.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.

Behaviour:
- Reset is asynchronous (rst high). It clears:
  - all pipeline, window and counter registers;
  - dout=0, out_valid=0, frame_done=0;
  - FSM state to IDLE.
- Reset mid-frame discards the partial frame.
- Accepted beat = clken && in_valid, in IDLE or RUN. Upstream delivers exactly width*height beats per frame in raster order.
- Tap contents when r=0 (top) or r=height-1 (bot) are don't-care.
- Input counters ic (column) and ir (row):
  - advance on each accepted beat;
  - ic wraps width-1 -> 0; ir increments on that wrap.
- width and height are latched on the first accepted beat of a frame (IDLE->RUN). Changes mid-frame are ignored.
- Window:
  - three 3-deep column shift registers, shifting on each accepted beat or flush beat;
  - the window centre is pixel (r, c-1) relative to the newest beat, i.e. one beat of horizontal lag;
  - centre coordinates (cr, cc) are tracked by a second counter pair that trails the input counters by one beat;
  - the first beat of a frame produces no output.
- Median datapath, advancing on clken cycles; each stage carries a valid bit:
  - S1: sort each column into min/med/max.
  - S2: compute max-of-mins, med-of-meds and min-of-maxes.
  - S3: take the median of those three, registered into dout.
- Latency: dout/out_valid are asserted on the 3rd clken cycle after the beat (or flush beat) that completes the window.
- Bubbles:
  - in_valid low inserts a bubble and the window does not shift;
  - cycles with clken low freeze every register, including out_valid, which holds its value.
- Border rule: if cr==0, cr==height-1, cc==0 or cc==width-1, dout = the centre (mid-tap) value, with identical latency.
- FSM:
  - IDLE: waits for the first accepted beat -> RUN.
  - RUN: on acceptance of beat (height-1, width-1) -> FLUSH.
  - FLUSH: the next clken cycle injects one synthetic beat (taps ignored, window shifts) to emit centre (height-1, width-1), then -> IDLE with counters zeroed.
  - in_valid during FLUSH is dropped.
- frame_done is asserted together with out_valid for centre (height-1, width-1).
- Output count per frame is exactly width*height.
- A new frame may begin on the clken cycle after FLUSH, while the previous frame's final pixel is still in S1–S3.

Optional Feature:
- Macro: MEDIAN_BORDER_ZERO_EN.
- Defined: border pixels output 0 instead of the centre value.
- Undefined: border pixels pass through the centre value.
- Latency and out_valid timing are identical in both cases.

Test Plan:
- width=3, height=3, mid rows = 1..9 raster, top/bot aligned accordingly:
  - 9 outputs;
  - centre (1,1) = 5;
  - all others equal their input values;
  - frame_done asserted with the 9th output.
- width=4, height=3, all pixels 10 except (1,1)=200 -> (1,1) outputs 10 and (1,2) outputs 10; the spike is removed.
- in_valid toggled 1,0,1,0 with clken=1 throughout -> output values are identical to the gap-free run, with out_valid gaps matching the input gaps.
- clken low for 5 cycles mid-frame -> all outputs frozen, then the stream resumes with no lost or duplicated pixels.
- rst pulse during row 1 of a 4x4 frame -> out_valid=0 and dout=0 immediately; the next full 4x4 frame produces exactly 16 outputs.
- With MEDIAN_BORDER_ZERO_EN defined, rerun the 3x3 ramp -> outputs 0,0,0,0,5,0,0,0,0.
